// File: rtl/sync_fifo_ext_if.sv
// rtl/sync_fifo_ext_if.sv - producer/consumer handshake and status bundle for sync_fifo_ext
interface sync_fifo_ext_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             clear;
    logic             write_en;
    logic [WIDTH-1:0] data_in;
    logic             read_en;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output clear, write_en, data_in, read_en,
        input  data_out, empty, full, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  clear, write_en, data_in, read_en,
        output data_out, empty, full, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ext.sv
// rtl/sync_fifo_ext.sv - single-clock FIFO, any depth, count/threshold flags, flush, error pulses
// Define SYNC_FIFO_EXT_SVA_EN to compile the embedded concurrent assertions.
module sync_fifo_ext #(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 8,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    sync_fifo_ext_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             rd_acc;
    logic             wr_acc;

    assign bus.count        = count_q;
    assign bus.empty        = (count_q == '0);
    assign bus.full         = (count_q == DEPTH_C);
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = bus.read_en && !bus.empty && !bus.clear;
    assign wr_acc = bus.write_en && !bus.clear && (!bus.full || rd_acc);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            bus.data_out  <= '0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            bus.overflow  <= bus.write_en && !wr_acc;
            bus.underflow <= bus.read_en && !rd_acc;
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                bus.data_out <= mem[rd_ptr];
                rd_ptr       <= (rd_ptr == LAST_C) ? '0 : rd_ptr + PW'(1);
            end
            if (wr_acc && !rd_acc) begin
                count_q <= count_q + CW'(1);
            end else if (rd_acc && !wr_acc) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

`ifdef SYNC_FIFO_EXT_SVA_EN
    a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= DEPTH_C)
        else $error("sync_fifo_ext: count exceeds DEPTH");

    a_empty_flag: assert property (@(posedge clk) disable iff (!rst_n)
        bus.empty == (count_q == '0))
        else $error("sync_fifo_ext: empty disagrees with count");

    a_full_flag: assert property (@(posedge clk) disable iff (!rst_n)
        bus.full == (count_q == DEPTH_C))
        else $error("sync_fifo_ext: full disagrees with count");

    a_count_inc: assert property (@(posedge clk) disable iff (!rst_n)
        (wr_acc && !rd_acc) |=> (count_q == $past(count_q) + CW'(1)))
        else $error("sync_fifo_ext: count did not increment on write");

    a_count_dec: assert property (@(posedge clk) disable iff (!rst_n)
        (rd_acc && !wr_acc) |=> (count_q == $past(count_q) - CW'(1)))
        else $error("sync_fifo_ext: count did not decrement on read");

    a_count_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (!bus.clear && (wr_acc == rd_acc)) |=> (count_q == $past(count_q)))
        else $error("sync_fifo_ext: count changed without a net transfer");

    // A second overflow cycle is only legal if write_en was still held.
    a_overflow_single: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.overflow && !bus.write_en) |=> !bus.overflow)
        else $error("sync_fifo_ext: overflow repeated for a single request");

    a_data_known: assert property (@(posedge clk) disable iff (!rst_n)
        rd_acc |=> !$isunknown(bus.data_out))
        else $error("sync_fifo_ext: data_out unknown after read");

    a_clear_empties: assert property (@(posedge clk) disable iff (!rst_n)
        bus.clear |=> (count_q == '0))
        else $error("sync_fifo_ext: count not zero after clear");
`endif
endmodule

// File: tb/tb_sync_fifo_ext.sv
// tb/tb_sync_fifo_ext.sv - directed self-checking bench for sync_fifo_ext (DEPTH=5)
module tb_sync_fifo_ext;
    localparam int DEPTH = 5;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    sync_fifo_ext_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    sync_fifo_ext #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .AF_THRESH(4), .AE_THRESH(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags packed as {empty, full, almost_full, almost_empty, overflow, underflow}
    function automatic logic [5:0] flags();
        return {bus.empty, bus.full, bus.almost_full, bus.almost_empty, bus.overflow, bus.underflow};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.clear = 1'b0; bus.write_en = 1'b0; bus.read_en = 1'b0; bus.data_in = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.count !== CW'(0)) begin
            failures++; $display("FAIL reset_count got=%0d exp=0", bus.count);
        end
        checks++;
        if (flags() !== 6'b100100) begin
            failures++; $display("FAIL reset_flags got=%b exp=100100", flags());
        end
        checks++;
        if (bus.data_out !== 8'h00) begin
            failures++; $display("FAIL reset_data_out got=%h exp=00", bus.data_out);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        logic [5:0] exp_f;
        for (int i = 1; i <= 5; i++) begin
            bus.write_en = 1'b1;
            bus.data_in  = 8'(8'h11 * i);
            tick();
            exp_f = {1'b0, (i == 5), (i >= 4), (i <= 1), 1'b0, 1'b0};
            checks++;
            if (bus.count !== CW'(i)) begin
                failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, bus.count, i);
            end
            checks++;
            if (flags() !== exp_f) begin
                failures++; $display("FAIL fill_flags[%0d] got=%b exp=%b", i, flags(), exp_f);
            end
        end
        idle();
    endtask

    task automatic test_overflow_drain();
        logic [7:0] exp_d;
        bus.write_en = 1'b1;
        bus.data_in  = 8'h66;
        tick();
        idle();
        checks++;
        if (bus.overflow !== 1'b1 || bus.count !== CW'(5)) begin
            failures++; $display("FAIL overflow_pulse got ov=%b cnt=%0d exp ov=1 cnt=5", bus.overflow, bus.count);
        end
        tick();
        checks++;
        if (bus.overflow !== 1'b0) begin
            failures++; $display("FAIL overflow_single got=%b exp=0", bus.overflow);
        end
        for (int i = 1; i <= 5; i++) begin
            bus.read_en = 1'b1;
            tick();
            exp_d = 8'(8'h11 * i);
            checks++;
            if (bus.data_out !== exp_d || bus.count !== CW'(5 - i)) begin
                failures++; $display("FAIL drain[%0d] got data=%h cnt=%0d exp data=%h cnt=%0d", i, bus.data_out, bus.count, exp_d, 5 - i);
            end
        end
        idle();
        checks++;
        if (bus.empty !== 1'b1) begin
            failures++; $display("FAIL drain_empty got=%b exp=1", bus.empty);
        end
    endtask

    task automatic test_underflow();
        bus.read_en = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.underflow !== 1'b1 || bus.data_out !== 8'h55 || bus.count !== CW'(0)) begin
            failures++; $display("FAIL underflow got un=%b data=%h cnt=%0d exp un=1 data=55 cnt=0", bus.underflow, bus.data_out, bus.count);
        end
        tick();
        checks++;
        if (bus.underflow !== 1'b0) begin
            failures++; $display("FAIL underflow_single got=%b exp=0", bus.underflow);
        end
    endtask

    task automatic test_wrap_simul();
        for (int i = 1; i <= 3; i++) begin
            bus.write_en = 1'b1;
            bus.data_in  = 8'(i);
            tick();
        end
        for (int i = 1; i <= 7; i++) begin
            bus.write_en = 1'b1;
            bus.read_en  = 1'b1;
            bus.data_in  = 8'(i + 3);
            tick();
            checks++;
            if (bus.data_out !== 8'(i) || bus.count !== CW'(3)) begin
                failures++; $display("FAIL wrap[%0d] got data=%h cnt=%0d exp data=%h cnt=3", i, bus.data_out, bus.count, 8'(i));
            end
        end
        idle();
        // Top up to full with 0x0B, 0x0C, then read+write at full.
        for (int i = 11; i <= 12; i++) begin
            bus.write_en = 1'b1;
            bus.data_in  = 8'(i);
            tick();
        end
        bus.read_en = 1'b1;
        bus.data_in = 8'h0D;
        tick();
        idle();
        checks++;
        if (bus.data_out !== 8'h08 || bus.count !== CW'(5) || flags() !== 6'b011000) begin
            failures++; $display("FAIL full_simul got data=%h cnt=%0d flags=%b exp data=08 cnt=5 flags=011000", bus.data_out, bus.count, flags());
        end
        tick();
        checks++;
        if (bus.overflow !== 1'b0) begin
            failures++; $display("FAIL full_simul_no_ov got=%b exp=0", bus.overflow);
        end
    endtask

    task automatic test_clear();
        bus.read_en = 1'b1;
        tick();
        tick();
        idle();
        checks++;
        if (bus.data_out !== 8'h0A || bus.count !== CW'(3)) begin
            failures++; $display("FAIL pre_clear got data=%h cnt=%0d exp data=0a cnt=3", bus.data_out, bus.count);
        end
        bus.clear    = 1'b1;
        bus.write_en = 1'b1;
        bus.read_en  = 1'b1;
        bus.data_in  = 8'hEE;
        tick();
        idle();
        checks++;
        if (bus.count !== CW'(0) || flags() !== 6'b100100 || bus.data_out !== 8'h0A) begin
            failures++; $display("FAIL clear got cnt=%0d flags=%b data=%h exp cnt=0 flags=100100 data=0a", bus.count, flags(), bus.data_out);
        end
        tick();
        checks++;
        if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.count !== CW'(0)) begin
            failures++; $display("FAIL clear_no_err got ov=%b un=%b cnt=%0d exp 0 0 0", bus.overflow, bus.underflow, bus.count);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 4; i++) begin
            bus.write_en = 1'b1;
            bus.data_in  = 8'(8'hB0 + i);
            tick();
        end
        bus.write_en = 1'b0;
        bus.read_en  = 1'b1;
        tick();
        bus.write_en = 1'b1;
        bus.read_en  = 1'b0;
        bus.data_in  = 8'hB5;
        tick();
        idle();
        checks++;
        if (bus.count !== CW'(4) || bus.data_out !== 8'hB1) begin
            failures++; $display("FAIL pre_reset got cnt=%0d data=%h exp cnt=4 data=b1", bus.count, bus.data_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.count !== CW'(0) || flags() !== 6'b100100 || bus.data_out !== 8'h00) begin
            failures++; $display("FAIL async_reset got cnt=%0d flags=%b data=%h exp cnt=0 flags=100100 data=00", bus.count, flags(), bus.data_out);
        end
        tick();
        rst_n = 1'b1;
        tick();
        bus.write_en = 1'b1;
        bus.data_in  = 8'hA5;
        tick();
        bus.write_en = 1'b0;
        bus.read_en  = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.data_out !== 8'hA5 || bus.empty !== 1'b1) begin
            failures++; $display("FAIL post_reset_rw got data=%h empty=%b exp data=a5 empty=1", bus.data_out, bus.empty);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        idle();
        #1;
        test_reset();
        test_fill();
        test_overflow_drain();
        test_underflow();
        test_wrap_simul();
        test_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
